// File: rtl/bus_reader.sv
// rtl/bus_reader.sv - bus receive FIFO: captures strobed bus words, drains over valid/ready
module bus_reader #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  bus_in,
    input  logic          bus_strobe,
    output logic          bus_busy,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_ovf
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;

    state_t state;
    logic   pop;
    logic   push;
    logic   drop;

    // Occupancy class is purely a function of count, so flags track it with no lag.
    always_comb begin
        state = ST_PARTIAL;
        if (count_q == '0) begin
            state = ST_EMPTY;
        end else if (count_q == DEPTH_C) begin
            state = ST_FULL;
        end
    end

    assign out_valid = (state != ST_EMPTY);
    assign bus_busy  = (state == ST_FULL);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

    // A pop frees a slot at the same edge, so a full FIFO still accepts a strobe then.
    assign pop  = out_valid & out_ready;
    assign push = bus_strobe & ((state != ST_FULL) | pop);
    assign drop = bus_strobe & (state == ST_FULL) & ~pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = bus_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A fresh drop wins over a coincident clear.
        overflow_d = drop | (overflow_q & ~clr_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_bus_reader.sv
// tb/tb_bus_reader.sv - scoreboard bench for bus_reader
module tb_bus_reader;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  bus_in;
    logic          bus_strobe;
    logic          bus_busy;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   count;
    logic          overflow;
    logic          clr_ovf;

    int n_checks = 0;
    int n_errors = 0;
    logic [N-1:0] exp_q [$];

    bus_reader #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_in     (bus_in),
        .bus_strobe (bus_strobe),
        .bus_busy   (bus_busy),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every accepted output word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL pop_unexpected: got %02h, want no word", out_data);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_errors++;
                    $display("FAIL pop_data: got %02h, want %02h", out_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [N-1:0] d, input bit accepted);
        bus_strobe = 1'b1;
        bus_in     = d;
        if (accepted) exp_q.push_back(d);
        tick();
        bus_strobe = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus_in     = 8'hFF;
        bus_strobe = 1'b1;
        out_ready  = 1'b0;
        clr_ovf    = 1'b0;

        // 1. reset with strobe held
        repeat (3) tick();
        check("rst_count",    32'(count),     32'd0);
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_busy",     32'(bus_busy),  32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        check("rst_data",     32'(out_data),  32'h00);
        bus_strobe = 1'b0;
        rst_n      = 1'b1;
        tick();
        check("post_rst_count", 32'(count), 32'd0);

        // 2. single transfer
        strobe(8'hF0, 1'b1);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data",  32'(out_data),  32'hF0);
        check("single_count", 32'(count),     32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_drain_count", 32'(count),     32'd0);
        check("single_drain_valid", 32'(out_valid), 32'd0);

        // 3. fill and overflow
        for (int i = 1; i <= 4; i++) begin
            check("fill_busy_before", 32'(bus_busy), 32'd0);
            strobe(8'(i), 1'b1);
        end
        check("fill_count",    32'(count),    32'd4);
        check("fill_busy",     32'(bus_busy), 32'd1);
        check("fill_overflow", 32'(overflow), 32'd0);
        strobe(8'h05, 1'b0);
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_count", 32'(count),    32'd4);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // 4. full with simultaneous push and pop
        out_ready = 1'b1;
        strobe(8'hAA, 1'b1);
        check("fullpp_count",    32'(count),    32'd4);
        check("fullpp_overflow", 32'(overflow), 32'd0);
        repeat (4) tick();
        out_ready = 1'b0;
        check("fullpp_drained", 32'(count), 32'd0);

        // 5. continuous stream wraps pointers
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            strobe(8'(i), 1'b1);
            check("stream_count", 32'(count), 32'd1);
        end
        tick();
        out_ready = 1'b0;
        check("stream_end_count", 32'(count), 32'd0);

        // 6a. mid-operation reset with count=3 and overflow=1
        for (int i = 0; i < 4; i++) strobe(8'h30 + 8'(i), 1'b1);
        strobe(8'h3F, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pre_rst_count",    32'(count),    32'd3);
        check("pre_rst_overflow", 32'(overflow), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_count",    32'(count),     32'd0);
        check("midrst_overflow", 32'(overflow),  32'd0);
        check("midrst_valid",    32'(out_valid), 32'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        strobe(8'h5A, 1'b1);
        check("post_rst_data", 32'(out_data), 32'h5A);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 6b. clear coincident with a new drop keeps overflow set
        for (int i = 0; i < 4; i++) strobe(8'hC0 + 8'(i), 1'b1);
        strobe(8'hCE, 1'b0);
        check("coinc_pre", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        strobe(8'hCF, 1'b0);
        check("coinc_stays", 32'(overflow), 32'd1);
        tick();
        clr_ovf = 1'b0;
        check("coinc_cleared", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;
        check("final_count", 32'(count), 32'd0);
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
